spw_tx_scheduler: RTL
=====================

Name: spw_tx_scheduler

Overview:
Character scheduler and flow-control credit manager for the SpaceWire codec, in the CLOCK (system) domain.
- Consumes the edge-detected RX event pulses produced by the RX-to-system synchroniser (gotFCT, gotNChar).
- Tracks transmit credit and outstanding receive credit.
- Decides which character the TX encoder sends next: time-code, FCT, N-char or NULL.
- Talks to the TX encoder through a request/acknowledge handshake.

Parameters:
MAX_CREDIT, 56, ceiling for both credit counters (ECSS-E-ST-50-12C)
FCT_STEP, 8, credit added per FCT sent or received
CNT_W, 6, width of credit counters; must satisfy 2^CNT_W > MAX_CREDIT

Ports:
CLOCK  in  1  system clock
RESETn  in  1  asynchronous, active-low reset
link_enable  in  1  link FSM in Connecting or Run; FCT/NULL allowed
link_run  in  1  link FSM in Run; N-char and time-code allowed
gotFCT_sys  in  1  one-cycle pulse per received FCT
gotNChar_sys  in  1  one-cycle pulse per received N-char
rx_buf_space  in  7  free words in RX buffer
tick_in  in  1  one-cycle time-code send request
time_in  in  8  time-code value, sampled with tick_in
tx_data_valid  in  1  TX FIFO non-empty
tx_data  in  9  TX FIFO head (bit 8 = control flag, EOP/EEP)
tx_data_rd  out  1  one-cycle FIFO pop strobe
char_req  out  1  character request to encoder
char_type  out  2  00 NULL, 01 FCT, 10 N-char, 11 time-code
char_data  out  9  N-char data or {1'b0, time value}
char_ack  in  1  one-cycle pulse: encoder accepted the current character
tx_credit  out  CNT_W  N-chars the far end permits
rx_credit  out  CNT_W  N-chars granted to the far end, not yet received
creditErr  out  1  credit error indication

Behaviour:
Reset: all outputs 0; FSM in IDLE; tick pending flag cleared.

FSM states: IDLE, SELECT, WAIT_ACK.
- IDLE: stay while link_enable=0. Otherwise go to SELECT next cycle.
- SELECT (one cycle): choose by fixed priority, latch char_type/char_data, assert char_req, go to WAIT_ACK.
  1. Time-code: tick pending AND link_run.
  2. FCT: rx_credit+FCT_STEP <= MAX_CREDIT AND rx_buf_space >= rx_credit+FCT_STEP.
  3. N-char: link_run AND tx_data_valid AND tx_credit>0.
  4. Otherwise NULL.
- WAIT_ACK: char_req, char_type and char_data held stable until char_ack. On char_ack:
  - char_req drops the same edge; return to SELECT.
  - FCT: rx_credit += FCT_STEP.
  - N-char: tx_credit -= 1; tx_data_rd pulses for one cycle.
  - Time-code: pending flag cleared.

Tick latch:
- tick_in sets the pending flag and captures time_in.
- A tick while already pending overwrites the captured value; only one time-code is sent.
- A tick in the same cycle as the time-code char_ack is kept pending.

TX credit:
- gotFCT_sys adds FCT_STEP.
- If the result would exceed MAX_CREDIT: creditErr asserts and tx_credit is unchanged.
- gotFCT_sys together with an N-char ack: net change +FCT_STEP-1, overflow checked on the net value.

RX credit:
- gotNChar_sys subtracts 1.
- gotNChar_sys with rx_credit==0: creditErr asserts, counter stays 0.
- gotNChar_sys together with an FCT ack: net +FCT_STEP-1.

creditErr: one-cycle pulse (see Optional Feature).

Link drop: link_enable=0 in any state forces, on the next edge:
- IDLE;
- char_req=0;
- both credits 0;
- pending tick cleared.
An outstanding char_ack in that same cycle is ignored, so no counter update and no tx_data_rd.

link_run falling while an N-char is in WAIT_ACK: the request is kept until char_ack (character already committed).

Latency:
- Link enable to first char_req: 2 cycles.
- char_ack to next char_req: 2 cycles.

Optional Feature:
Macro SPW_CREDIT_ERR_STICKY_EN.
- Defined: creditErr is sticky; it sets on any credit error and clears only when link_enable=0 or on reset.
- Undefined: creditErr is a one-cycle pulse per error event.

Test Plan:
1. Reset release, link_enable=1, rx_buf_space=64, ack each char 3 cycles after char_req → sequence: seven FCTs with rx_credit 8..56, then NULLs; no N-char while tx_credit=0.
2. link_run=1, seven gotFCT pulses, tx_data_valid=1 with 10 words → tx_credit reaches 56, then 10 N-chars in FIFO order, tx_data_rd pulsed 10×, tx_credit ends at 46.
3. tx_credit=56, another gotFCT_sys → creditErr pulse (sticky when SPW_CREDIT_ERR_STICKY_EN), tx_credit stays 56.
4. tick_in with time_in=0x15 during an N-char WAIT_ACK, second tick with 0x16 before that ack → the next char is a single time-code with char_data=0x016; the N-char resumes afterwards.
5. rx_credit=0, gotNChar_sys → creditErr; rx_credit=8 with a simultaneous FCT ack and gotNChar_sys → rx_credit=15.
6. link_enable dropped while in WAIT_ACK with char_ack in the same cycle → next cycle char_req=0, credits 0, FSM IDLE, no tx_data_rd.

Source files
------------

// File: rtl/spw_tx_scheduler.sv
// ---------------------------------------------------------------------------
// spw_tx_scheduler
//
// Character scheduler and flow-control credit manager for the SpaceWire
// codec (system clock domain). Picks the next character for the TX encoder
// by fixed priority (time-code, FCT, N-char, NULL) and tracks both credits.
//
// Ports:
//   CLOCK, RESETn              system clock, asynchronous active-low reset
//   link_enable, link_run      link FSM status (Connecting/Run, Run)
//   gotFCT_sys, gotNChar_sys   one-cycle RX event pulses
//   rx_buf_space               free words in the RX buffer
//   tick_in, time_in           time-code send request and value
//   tx_data_valid, tx_data     TX FIFO head (bit 8 = control flag)
//   tx_data_rd                 FIFO pop strobe
//   char_req/char_type/char_data/char_ack  encoder handshake
//   tx_credit, rx_credit       credit counters
//   creditErr                  credit error indication
//
// Build option:
//   SPW_CREDIT_ERR_STICKY_EN   when defined, creditErr holds until the link
//                              is disabled; otherwise it pulses per error.
// ---------------------------------------------------------------------------
module spw_tx_scheduler #(
  parameter int MAX_CREDIT = 56,
  parameter int FCT_STEP   = 8,
  parameter int CNT_W      = 6
) (
  input  logic             CLOCK,
  input  logic             RESETn,
  input  logic             link_enable,
  input  logic             link_run,
  input  logic             gotFCT_sys,
  input  logic             gotNChar_sys,
  input  logic [6:0]       rx_buf_space,
  input  logic             tick_in,
  input  logic [7:0]       time_in,
  input  logic             tx_data_valid,
  input  logic [8:0]       tx_data,
  output logic             tx_data_rd,
  output logic             char_req,
  output logic [1:0]       char_type,
  output logic [8:0]       char_data,
  input  logic             char_ack,
  output logic [CNT_W-1:0] tx_credit,
  output logic [CNT_W-1:0] rx_credit,
  output logic             creditErr
);

  // Wide enough for credit + FCT_STEP and for the 7-bit buffer space.
  localparam int SUM_W = (CNT_W + 2 > 8) ? CNT_W + 2 : 8;
  localparam logic [SUM_W-1:0] STEP_S = SUM_W'(FCT_STEP);
  localparam logic [SUM_W-1:0] MAX_S  = SUM_W'(MAX_CREDIT);
  localparam logic [SUM_W-1:0] ONE_S  = SUM_W'(1);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(FCT_STEP);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  localparam logic [1:0] TYPE_NULL  = 2'b00;
  localparam logic [1:0] TYPE_FCT   = 2'b01;
  localparam logic [1:0] TYPE_NCHAR = 2'b10;
  localparam logic [1:0] TYPE_TIME  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_WAIT_ACK} state_t;

  state_t           state_q, state_d;
  logic             char_req_q, char_req_d;
  logic [1:0]       char_type_q, char_type_d;
  logic [8:0]       char_data_q, char_data_d;
  logic [CNT_W-1:0] tx_credit_q, tx_credit_d;
  logic [CNT_W-1:0] rx_credit_q, rx_credit_d;
  logic             credit_err_q, credit_err_d;
  logic             tick_pend_q, tick_pend_d;
  logic [7:0]       time_q, time_d;

  logic             ack_fire, nchar_done, fct_done, time_done;
  logic [SUM_W-1:0] tx_net, rx_next_fct;
  logic [CNT_W-1:0] rx_net, tx_dec;
  logic             tx_ovf, rx_unf, time_ok, fct_ok, nchar_ok, err_event;

  // Handshake completion and credit arithmetic. An ack that coincides with
  // a link drop is ignored, so it never touches counters or the FIFO.
  always_comb begin
    ack_fire    = (state_q == ST_WAIT_ACK) && char_ack && link_enable;
    nchar_done  = ack_fire && (char_type_q == TYPE_NCHAR);
    fct_done    = ack_fire && (char_type_q == TYPE_FCT);
    time_done   = ack_fire && (char_type_q == TYPE_TIME);

    tx_dec      = tx_credit_q - (nchar_done ? ONE_C : '0);
    tx_net      = SUM_W'(tx_credit_q) + (gotFCT_sys ? STEP_S : '0)
                  - (nchar_done ? ONE_S : '0);
    // On overflow the received FCT is discarded; a completed N-char still
    // consumes its credit because that character has already gone out.
    tx_ovf      = gotFCT_sys && (tx_net > MAX_S);

    rx_net      = rx_credit_q + (fct_done ? STEP_C : '0)
                  - (gotNChar_sys ? ONE_C : '0);
    rx_unf      = gotNChar_sys && !fct_done && (rx_credit_q == '0);

    rx_next_fct = SUM_W'(rx_credit_q) + STEP_S;
    time_ok     = tick_pend_q && link_run;
    fct_ok      = (rx_next_fct <= MAX_S) && (SUM_W'(rx_buf_space) >= rx_next_fct);
    nchar_ok    = link_run && tx_data_valid && (tx_credit_q != '0);
    err_event   = tx_ovf || rx_unf;
  end

  // The FIFO pops on the accepting edge itself so that the following SELECT
  // already sees the next head word.
  assign tx_data_rd = nchar_done;

  always_comb begin
    state_d      = state_q;
    char_req_d   = char_req_q;
    char_type_d  = char_type_q;
    char_data_d  = char_data_q;
    tx_credit_d  = tx_credit_q;
    rx_credit_d  = rx_credit_q;
    credit_err_d = 1'b0;
    tick_pend_d  = tick_pend_q;
    time_d       = time_q;

    if (!link_enable) begin
      state_d     = ST_IDLE;
      char_req_d  = 1'b0;
      char_type_d = TYPE_NULL;
      char_data_d = '0;
      tx_credit_d = '0;
      rx_credit_d = '0;
      tick_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SELECT;
        ST_SELECT: begin
          char_req_d = 1'b1;
          state_d    = ST_WAIT_ACK;
          if (time_ok) begin
            char_type_d = TYPE_TIME;
            char_data_d = {1'b0, time_q};
          end else if (fct_ok) begin
            char_type_d = TYPE_FCT;
            char_data_d = '0;
          end else if (nchar_ok) begin
            char_type_d = TYPE_NCHAR;
            char_data_d = tx_data;
          end else begin
            char_type_d = TYPE_NULL;
            char_data_d = '0;
          end
        end
        ST_WAIT_ACK: begin
          // A committed N-char stays requested even if link_run falls.
          if (char_ack) begin
            char_req_d = 1'b0;
            state_d    = ST_SELECT;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      tx_credit_d = tx_ovf ? tx_dec : tx_net[CNT_W-1:0];
      rx_credit_d = rx_unf ? '0 : rx_net;

      // A new tick wins over the ack of the previous time-code.
      if (tick_in) begin
        tick_pend_d = 1'b1;
        time_d      = time_in;
      end else if (time_done) begin
        tick_pend_d = 1'b0;
      end

`ifdef SPW_CREDIT_ERR_STICKY_EN
      credit_err_d = credit_err_q || err_event;
`else
      credit_err_d = err_event;
`endif
    end
  end

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= ST_IDLE;
      char_req_q   <= 1'b0;
      char_type_q  <= TYPE_NULL;
      char_data_q  <= '0;
      tx_credit_q  <= '0;
      rx_credit_q  <= '0;
      credit_err_q <= 1'b0;
      tick_pend_q  <= 1'b0;
      time_q       <= '0;
    end else begin
      state_q      <= state_d;
      char_req_q   <= char_req_d;
      char_type_q  <= char_type_d;
      char_data_q  <= char_data_d;
      tx_credit_q  <= tx_credit_d;
      rx_credit_q  <= rx_credit_d;
      credit_err_q <= credit_err_d;
      tick_pend_q  <= tick_pend_d;
      time_q       <= time_d;
    end
  end

  assign char_req  = char_req_q;
  assign char_type = char_type_q;
  assign char_data = char_data_q;
  assign tx_credit = tx_credit_q;
  assign rx_credit = rx_credit_q;
  assign creditErr = credit_err_q;

endmodule
